cavlc_coeff_stats: RTL and testbench



---
 rtl/cavlc_coeff_stats.sv | 76 +++++++
 tb/tb_cavlc_coeff_stats.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cavlc_coeff_stats.sv
// CAVLC per-block statistics: non-zero count, total_zeros, trailing-ones count and signs.
// Coefficients arrive serially in reverse zig-zag order, one per clock, 16 per block.
module cavlc_coeff_stats (
    input  logic       clk,
    input  logic       rst,
    input  logic       trailOneEn,
    input  logic [8:0] word,
    output logic [4:0] NZQ_num,
    output logic [3:0] totalZerosNum,
    output logic [1:0] trailOneNum,
    output logic [2:0] trailOneSign
);

    localparam logic [4:0] IDLE_IDX = 5'd16;

    logic [4:0] idx;
    logic       seen_nz;
    logic       t1_open;
    logic       is_zero;
    logic       is_one;
    logic       t1_take;
    logic [2:0] sign_next;

    assign is_zero = (word[7:0] == 8'd0);
    assign is_one  = (word[7:0] == 8'd1);
    assign t1_take = t1_open && is_one && (trailOneNum != 2'd3);

    // The sign bits start cleared, so OR-ing in the new sign at the run position is enough.
    always_comb begin
        sign_next = trailOneSign;
        case (trailOneNum)
            2'd0:    sign_next[0] = word[8];
            2'd1:    sign_next[1] = word[8];
            2'd2:    sign_next[2] = word[8];
            default: sign_next = trailOneSign;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx           <= IDLE_IDX;
            seen_nz       <= 1'b0;
            t1_open       <= 1'b0;
            NZQ_num       <= 5'd0;
            totalZerosNum <= 4'd0;
            trailOneNum   <= 2'd0;
            trailOneSign  <= 3'd0;
        end else if (trailOneEn) begin
            idx           <= 5'd0;
            seen_nz       <= 1'b0;
            t1_open       <= 1'b1;
            NZQ_num       <= 5'd0;
            totalZerosNum <= 4'd0;
            trailOneNum   <= 2'd0;
            trailOneSign  <= 3'd0;
        end else if (idx < IDLE_IDX) begin
            idx <= idx + 5'd1;
            // Zeros ahead of the first non-zero are high-frequency padding, not total_zeros.
            if (is_zero) begin
                if (seen_nz) begin
                    totalZerosNum <= totalZerosNum + 4'd1;
                end
            end else begin
                NZQ_num <= NZQ_num + 5'd1;
                seen_nz <= 1'b1;
                if (t1_take) begin
                    trailOneSign <= sign_next;
                    trailOneNum  <= trailOneNum + 2'd1;
                end else begin
                    t1_open <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cavlc_coeff_stats.sv
// Scoreboard bench for cavlc_coeff_stats: a reference model pushes expected running
// statistics per driven cycle; they are popped and compared after each rising edge.
module tb_cavlc_coeff_stats;

    typedef struct packed {
        logic [4:0] nz;
        logic [3:0] zeros;
        logic [1:0] t1;
        logic [2:0] sign;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       trailOneEn;
    logic [8:0] word;
    logic [4:0] NZQ_num;
    logic [3:0] totalZerosNum;
    logic [1:0] trailOneNum;
    logic [2:0] trailOneSign;

    int compared   = 0;
    int mismatched = 0;

    exp_t exp_q[$];
    exp_t m;
    int   m_idx;
    logic m_seen;
    logic m_open;
    logic [8:0] blk[16];

    cavlc_coeff_stats dut (
        .clk           (clk),
        .rst           (rst),
        .trailOneEn    (trailOneEn),
        .word          (word),
        .NZQ_num       (NZQ_num),
        .totalZerosNum (totalZerosNum),
        .trailOneNum   (trailOneNum),
        .trailOneSign  (trailOneSign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        if (obs !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference behaviour of one clock edge.
    task automatic modelStep(input logic r, input logic en, input logic [8:0] w);
        if (!r) begin
            m = '0; m_idx = 16; m_seen = 1'b0; m_open = 1'b0;
        end else if (en) begin
            m = '0; m_idx = 0; m_seen = 1'b0; m_open = 1'b1;
        end else if (m_idx < 16) begin
            m_idx++;
            if (w[7:0] == 8'd0) begin
                if (m_seen) m.zeros = m.zeros + 4'd1;
            end else begin
                m.nz = m.nz + 5'd1;
                m_seen = 1'b1;
                if (m_open && w[7:0] == 8'd1 && m.t1 < 2'd3) begin
                    m.sign[m.t1] = w[8];
                    m.t1 = m.t1 + 2'd1;
                end else begin
                    m_open = 1'b0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic [8:0] w, input string tag);
        exp_t e;
        @(negedge clk);
        rst = r;
        trailOneEn = en;
        word = w;
        modelStep(r, en, w);
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checkOutput({tag, ".nz"},    32'(NZQ_num),       32'(e.nz));
        checkOutput({tag, ".zeros"}, 32'(totalZerosNum), 32'(e.zeros));
        checkOutput({tag, ".t1"},    32'(trailOneNum),   32'(e.t1));
        checkOutput({tag, ".sign"},  32'(trailOneSign),  32'(e.sign));
    endtask

    task automatic runBlock(input string tag);
        applyStimulus(1'b1, 1'b1, 9'h0AA, {tag, ".start"});
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, blk[i], tag);
    endtask

    task automatic checkFinal(input string tag, input int nz, input int zeros, input int t1, input int sign);
        checkOutput({tag, ".final_nz"},    32'(NZQ_num),       32'(nz));
        checkOutput({tag, ".final_zeros"}, 32'(totalZerosNum), 32'(zeros));
        checkOutput({tag, ".final_t1"},    32'(trailOneNum),   32'(t1));
        checkOutput({tag, ".final_sign"},  32'(trailOneSign),  32'(sign));
    endtask

    function automatic logic [8:0] randWord();
        logic [8:0] w;
        w[8]   = 1'($urandom_range(0, 1));
        w[7:0] = 8'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        rst = 1'b0;
        trailOneEn = 1'b0;
        word = 9'h000;
        m = '0; m_idx = 16; m_seen = 1'b0; m_open = 1'b0;

        applyStimulus(1'b0, 1'b0, 9'h101, "reset");
        applyStimulus(1'b0, 1'b1, 9'h001, "reset_pri");
        checkFinal("reset", 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, randWord(), "idle");
        checkFinal("idle", 0, 0, 0, 0);

        for (int i = 0; i < 9; i++) blk[i] = 9'h000;
        blk[9] = 9'h101; blk[10] = 9'h000; blk[11] = 9'h000; blk[12] = 9'h103;
        blk[13] = 9'h003; blk[14] = 9'h004; blk[15] = 9'h102;
        runBlock("mixed");
        checkFinal("mixed", 5, 2, 1, 1);

        blk[0] = 9'h001; blk[1] = 9'h101; blk[2] = 9'h001; blk[3] = 9'h101;
        for (int i = 4; i < 16; i++) blk[i] = 9'h000;
        runBlock("ones");
        checkFinal("ones", 4, 12, 3, 2);

        for (int i = 0; i < 16; i++) blk[i] = 9'h000;
        blk[7] = 9'h100;
        runBlock("allzero");
        checkFinal("allzero", 0, 0, 0, 0);

        for (int i = 0; i < 16; i++) blk[i] = 9'h002;
        runBlock("alltwo");
        checkFinal("alltwo", 16, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 9'h001, "extra");
        checkFinal("extra", 16, 0, 0, 0);

        applyStimulus(1'b1, 1'b1, 9'h000, "abort.start");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 9'h001, "abort.pre");
        for (int i = 0; i < 16; i++) blk[i] = randWord();
        runBlock("abort.post");

        applyStimulus(1'b1, 1'b1, 9'h000, "rstmid.start");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 9'h103, "rstmid.pre");
        applyStimulus(1'b0, 1'b0, 9'h001, "rstmid.rst");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, randWord(), "rstmid.ignored");
        checkFinal("rstmid", 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) blk[i] = randWord();
        runBlock("rstmid.next");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
